// File: rtl/mbist_pkg.sv
// Purpose: shared FSM state codes and March C- element tables for the RAM BIST.
// Latency: n/a (constants and a pure lookup function only).
// Backpressure: n/a.
package mbist_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // March element indices
  localparam logic [2:0] M0     = 3'd0;
  localparam logic [2:0] M1     = 3'd1;
  localparam logic [2:0] M2     = 3'd2;
  localparam logic [2:0] M3     = 3'd3;
  localparam logic [2:0] M4     = 3'd4;
  localparam logic [2:0] M5     = 3'd5;
  localparam logic [2:0] M_LAST = M5;

  // Op phase within one address
  localparam logic PH_R = 1'b0;
  localparam logic PH_W = 1'b1;

  // Per-element attributes, bit i describes element Mi (bits 7:6 unused).
  // March C-: M0 up(wD) M1 up(rD,wI) M2 up(rI,wD) M3 dn(rD,wI) M4 dn(rI,wD) M5 up(rD)
  localparam logic [7:0] ELEM_DOWN     = 8'b0001_1000;
  localparam logic [7:0] ELEM_HAS_READ = 8'b0011_1110;
  localparam logic [7:0] ELEM_RD_INV   = 8'b0001_0100;
  localparam logic [7:0] ELEM_HAS_WR   = 8'b0001_1111;
  localparam logic [7:0] ELEM_WR_INV   = 8'b0000_1010;

  function automatic logic elem_bit(input logic [7:0] tbl, input logic [2:0] e);
    return tbl[e];
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Purpose: loadable up/down address counter with terminal-count flag for the March sweep.
// Latency: load/step take effect at the next clk edge; last is combinational from the count.
// Backpressure: none; the counter only moves when step or load is asserted.
// Ports: load/load_down preset to 0 or DEPTH-1; step moves one address in direction down;
//        addr is the current address; last flags DEPTH-1 (up) or 0 (down).
module mbist_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_down ? TOP_ADDR : '0;
    end else if (step) begin
      addr_d = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = down ? (addr_q == '0) : (addr_q == TOP_ADDR);

endmodule

// File: rtl/ram_march_bist.sv
// Purpose: March C- BIST controller driving a synchronous RAM and checking its registered read data.
// Latency: one RAM op per cycle, 10*DEPTH op cycles + 1 drain cycle; done rises 10*DEPTH+1 edges after start.
// Backpressure: none; start is ignored while busy, the RAM is assumed always ready.
// Ports: start/busy/done/fail plus first-failure syndrome fail_elem/addr/exp/act;
//        mem_wr/mem_address/mem_data_in drive the RAM, mem_data_out is its 1-cycle-latency read data.
module ram_march_bist
  import mbist_pkg::*;
#(
  parameter int              ADDR_W       = 10,
  parameter int              DATA_W       = 8,
  parameter int              DEPTH        = 1024,
  parameter logic [DATA_W-1:0] BG         = '0,
  parameter bit              STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              phase_q, phase_d;
  logic              fail_q, fail_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_act_q, fail_act_d;
  // Read-check pipeline: what the read issued last cycle should return
  logic              chk_vld_q, chk_vld_d;
  logic [DATA_W-1:0] chk_exp_q, chk_exp_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [2:0]        chk_elem_q, chk_elem_d;

  logic              ag_load, ag_load_down, ag_step, ag_last;
  logic [ADDR_W-1:0] ag_addr;

  logic              in_run, op_wr, op_rd, addr_done, miscmp, stop_now, start_ok;
  logic              cur_down, cur_has_rd, cur_has_wr;
  logic [2:0]        nxt_elem;
  logic [DATA_W-1:0] rd_pat, wr_pat;

  mbist_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .down      (cur_down),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  assign cur_down   = elem_bit(ELEM_DOWN, elem_q);
  assign cur_has_rd = elem_bit(ELEM_HAS_READ, elem_q);
  assign cur_has_wr = elem_bit(ELEM_HAS_WR, elem_q);
  assign rd_pat     = elem_bit(ELEM_RD_INV, elem_q) ? ~BG : BG;
  assign wr_pat     = elem_bit(ELEM_WR_INV, elem_q) ? ~BG : BG;
  assign nxt_elem   = elem_q + 3'd1;

  assign in_run    = (state_q == ST_RUN);
  assign op_wr     = in_run && (phase_q == PH_W);
  assign op_rd     = in_run && (phase_q == PH_R);
  // Address advances after its write, or after its read in read-only elements
  assign addr_done = op_wr || !cur_has_wr;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign miscmp    = chk_vld_q && (mem_data_out != chk_exp_q);
  assign stop_now  = STOP_ON_FAIL && miscmp;

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    // Suppress a pending check once the run is stopping so DONE never compares stale data
    chk_vld_d    = op_rd && !stop_now;
    chk_exp_d    = rd_pat;
    chk_addr_d   = ag_addr;
    chk_elem_d   = elem_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d      = ST_RUN;
          elem_d       = M0;
          phase_d      = elem_bit(ELEM_HAS_READ, M0) ? PH_R : PH_W;
          ag_load      = 1'b1;
          ag_load_down = elem_bit(ELEM_DOWN, M0);
        end
      end
      ST_RUN: begin
        if (!addr_done) begin
          phase_d = PH_W;
        end else if (!ag_last) begin
          ag_step = 1'b1;
          phase_d = cur_has_rd ? PH_R : PH_W;
        end else if (elem_q == M_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          elem_d       = nxt_elem;
          phase_d      = elem_bit(ELEM_HAS_READ, nxt_elem) ? PH_R : PH_W;
          ag_load      = 1'b1;
          ag_load_down = elem_bit(ELEM_DOWN, nxt_elem);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    if (stop_now) begin
      state_d = ST_DONE;
    end
  end

  // First-failure syndrome: cleared by an accepted start, latched once per run
  always_comb begin
    fail_d      = fail_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_elem_d = '0;
      fail_addr_d = '0;
      fail_exp_d  = '0;
      fail_act_d  = '0;
    end else if (miscmp && !fail_q) begin
      fail_d      = 1'b1;
      fail_elem_d = chk_elem_q;
      fail_addr_d = chk_addr_q;
      fail_exp_d  = chk_exp_q;
      fail_act_d  = mem_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= M0;
      phase_q     <= PH_R;
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      chk_vld_q   <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
      chk_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      fail_q      <= fail_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
      chk_vld_q   <= chk_vld_d;
      chk_exp_q   <= chk_exp_d;
      chk_addr_q  <= chk_addr_d;
      chk_elem_q  <= chk_elem_d;
    end
  end

  // RAM controls decode straight from state flops, so reset silences them asynchronously
  assign mem_wr      = op_wr;
  assign mem_address = in_run ? ag_addr : '0;
  assign mem_data_in = op_wr ? wr_pat : '0;

  assign busy      = in_run || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign fail      = fail_q;
  assign fail_elem = fail_elem_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;

endmodule

// File: tb/tb_ram_march_bist.sv
module tb_ram_march_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // Default-parameter DUT (1024x8, BG=00, stop on fail)
  logic       start, busy, done, fail, mem_wr;
  logic [2:0] fail_elem;
  logic [9:0] fail_addr, mem_address;
  logic [7:0] fail_exp, fail_act, mem_data_in, mem_data_out;

  ram_march_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
    .mem_wr(mem_wr), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Small DUT: DEPTH=16, BG=55, run to completion
  logic       start16, busy16, done16, fail16, mem16_wr;
  logic [2:0] fail16_elem;
  logic [9:0] fail16_addr, mem16_address;
  logic [7:0] fail16_exp, fail16_act, mem16_data_in, mem16_data_out;

  ram_march_bist #(.DEPTH(16), .BG(8'h55), .STOP_ON_FAIL(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16), .fail(fail16),
    .fail_elem(fail16_elem), .fail_addr(fail16_addr), .fail_exp(fail16_exp),
    .fail_act(fail16_act), .mem_wr(mem16_wr), .mem_address(mem16_address),
    .mem_data_in(mem16_data_in), .mem_data_out(mem16_data_out)
  );

  // RAM models. fault_mode: 0 clean, 1 addr 5 bit 3 stuck-at-1, 2 address LSB forced to 1
  int         fault_mode = 0;
  logic [7:0] ram   [0:1023];
  logic [7:0] ram16 [0:1023];
  logic [9:0] phys_a;

  always_comb phys_a = (fault_mode == 2) ? (mem_address | 10'd1) : mem_address;

  always @(posedge clk) begin
    if (mem_wr) ram[phys_a] <= mem_data_in;
    mem_data_out <= (fault_mode == 1 && phys_a == 10'd5) ? (ram[phys_a] | 8'h08) : ram[phys_a];
  end

  // Address 15 bit 0 stuck-at-0
  always @(posedge clk) begin
    if (mem16_wr) ram16[mem16_address] <= mem16_data_in;
    mem16_data_out <= (mem16_address == 10'd15) ? (ram16[mem16_address] & 8'hFE)
                                                : ram16[mem16_address];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         fault;
    int         repulse_at;   // cycle at which start is re-pulsed while busy, 0 = never
    int         exp_cycles;   // edges from the accepting edge until done is seen
    int         exp_wr;
    int         exp_rd;
    logic       exp_fail;
    logic [2:0] exp_elem;
    logic [9:0] exp_addr;
    logic [7:0] exp_exp;
    logic [7:0] exp_act;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input string tag);
    int n, wr, rd, late_wr;
    bit finished;
    fault_mode = v.fault;
    start = 1'b1;
    step();                       // accepting edge ("edge 0")
    start = 1'b0;
    chk({tag, "_busy_at_start"}, busy, 1);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_fail_clear"}, fail, 0);
    chk({tag, "_syndrome_clear"}, {fail_elem, fail_addr, fail_exp, fail_act}, 0);
    n = 0; wr = 0; rd = 0; finished = 0;
    while (n < 12000 && !finished) begin
      if (busy) begin
        if (mem_wr) wr++;
        else if (n < 10240) rd++;     // cycle 10240 is the drain cycle, not a read
      end
      start = (v.repulse_at != 0 && n == v.repulse_at);
      step();
      n++;
      if (done) finished = 1;
    end
    start = 1'b0;
    chk({tag, "_done_edge"}, n, v.exp_cycles);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_writes"}, wr, v.exp_wr);
    chk({tag, "_reads"}, rd, v.exp_rd);
    chk({tag, "_fail"}, fail, v.exp_fail);
    chk({tag, "_fail_elem"}, fail_elem, v.exp_elem);
    chk({tag, "_fail_addr"}, fail_addr, v.exp_addr);
    chk({tag, "_fail_exp"}, fail_exp, v.exp_exp);
    chk({tag, "_fail_act"}, fail_act, v.exp_act);
    late_wr = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_wr) late_wr++;
      step();
    end
    chk({tag, "_no_wr_after_done"}, late_wr, 0);
    chk({tag, "_done_held"}, done, 1);
  endtask

  initial begin
    int n, idle_wr;
    bit finished;

    //           fault rep   cycles wr    rd    fail elem addr    exp    act
    vecs[0] = '{0,    0,    10241, 5120, 5120, 1'b0, 3'd0, 10'd0, 8'h00, 8'h00};
    vecs[1] = '{1,    0,    1036,  1030, 6,    1'b1, 3'd1, 10'd5, 8'h00, 8'h08};
    vecs[2] = '{2,    0,    1028,  1026, 2,    1'b1, 3'd1, 10'd1, 8'h00, 8'hFF};
    vecs[3] = '{0,    3000, 10241, 5120, 5120, 1'b0, 3'd0, 10'd0, 8'h00, 8'h00};

    rst_n = 1'b0;
    start = 1'b0;
    start16 = 1'b0;
    #1;
    chk("reset_outputs", {busy, done, fail, mem_wr, mem_address, mem_data_in}, 0);
    chk("reset_syndrome", {fail_elem, fail_addr, fail_exp, fail_act}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_outputs", {busy, done, mem_wr, mem_address, mem_data_in}, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Small array, no stop on fail: runs to 161 and keeps the first syndrome (M1)
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    chk("d16_busy", busy16, 1);
    n = 0; finished = 0;
    while (n < 400 && !finished) begin
      step();
      n++;
      if (done16) finished = 1;
    end
    chk("d16_done_edge", n, 161);
    chk("d16_fail", fail16, 1);
    chk("d16_fail_elem", fail16_elem, 1);
    chk("d16_fail_addr", fail16_addr, 15);
    chk("d16_fail_exp", fail16_exp, 8'h55);
    chk("d16_fail_act", fail16_act, 8'h54);

    // Reset during M3 at address 700 (read at cycle 5766, write at 5767)
    fault_mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5766; i++) step();
    chk("m3_read_addr", mem_address, 700);
    chk("m3_read_wr", mem_wr, 0);
    step();
    chk("m3_write_addr", mem_address, 700);
    chk("m3_write_wr", mem_wr, 1);
    chk("m3_write_data", mem_data_in, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr", mem_wr, 0);
    chk("midrst_status", {busy, done, fail}, 0);
    step();
    rst_n = 1'b1;
    idle_wr = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_wr) idle_wr++;
      step();
    end
    chk("post_rst_no_wr", idle_wr, 0);
    chk("post_rst_idle", {busy, done}, 0);
    run_vec(vecs[0], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test controller that sits directly upstream of the 1024x8 synchronous RAM and drives its wr/address/data_in ports.
- Consumes the RAM's registered data_out and checks it.
- Runs a March C- algorithm over every address, then reports pass/fail with the first-failure syndrome.
- Used in directed verification to catch addressing and storage faults in the RAM.

Parameters:
- ADDR_W, 10, address width.
- DATA_W, 8, data width.
- DEPTH, 1024, number of locations tested (addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W).
- BG, 8'h00, background pattern; the inverse pattern is ~BG.
- STOP_ON_FAIL, 1, 1 = stop at first miscompare; 0 = finish the full run, keep first syndrome.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a test
- busy  out  1  test in progress
- done  out  1  test finished; level, held until next accepted start
- fail  out  1  at least one miscompare; valid when done=1
- fail_elem  out  3  March element (0..5) of first miscompare
- fail_addr  out  ADDR_W  address of first miscompare
- fail_exp  out  DATA_W  expected data of first miscompare
- fail_act  out  DATA_W  read data of first miscompare
- mem_wr  out  1  to RAM wr
- mem_address  out  ADDR_W  to RAM address
- mem_data_in  out  DATA_W  to RAM data_in
- mem_data_out  in  DATA_W  from RAM data_out (registered, 1-cycle read latency)

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-low (rst_n). While rst_n=0:
  - all outputs are 0, state=IDLE;
  - mem_wr drops to 0 immediately (asynchronous).
- IDLE: mem_wr=0, mem_address=0, mem_data_in=0.
- start is sampled on a rising edge:
  - accepted only in IDLE or DONE;
  - on acceptance: done, fail and all fail_* fields clear; busy=1 from the same edge;
  - ignored while busy.
- March C- sequence (D=BG, I=~BG):
  - M0 up (w D)
  - M1 up (r D, w I)
  - M2 up (r I, w D)
  - M3 down (r D, w I)
  - M4 down (r I, w D)
  - M5 up (r D)
  - "up" = address 0..DEPTH-1; "down" = DEPTH-1..0.
- Timing and ordering:
  - One RAM operation per cycle.
  - Within an element, all ops for one address complete before the address advances.
  - Elements run back-to-back with no idle cycle.
  - Total: 10*DEPTH op cycles.
- Read check:
  - A read drives mem_wr=0 and the address in cycle t.
  - The RAM registers data_out at the end of t.
  - The controller compares mem_data_out against an expected/addr/elem value pipelined by one cycle, during cycle t+1.
  - The write to the same address proceeds in t+1, in parallel with the compare; no stall.
- Completion:
  - After the last op, one DRAIN cycle performs the final compare (no RAM op; mem_wr=0).
  - Then DONE: busy=0, done=1.
  - With start accepted at edge 0, done=1 after edge 10*DEPTH+1 (10241 for the defaults) on a clean RAM.
- Miscompare:
  - First miscompare: fail=1 and fail_* latched.
  - Later miscompares do not overwrite fail_*.
  - STOP_ON_FAIL=1: the FSM goes to DONE at the next edge; no further RAM ops are issued.
  - STOP_ON_FAIL=0: the run continues to normal completion.
- States: IDLE -> RUN (element index 0..5, op phase R/W) -> DRAIN -> DONE -> (start) RUN.
- Address counter:
  - wraps only at element boundaries;
  - loads 0 for up elements, DEPTH-1 for down elements;
  - arithmetic is ADDR_W bits unsigned;
  - terminal flag at DEPTH-1 (up) or 0 (down).
- Reset mid-run: everything is abandoned; after release the block is in IDLE and needs a new start. RAM contents are not assumed.

Decomposition:
- Shared package mbist_pkg holds:
  - state enum;
  - element index constants M0..M5;
  - per-element constants: direction, has_read, read pattern select, has_write, write pattern select.
- Single sub-module mbist_addr_gen: loadable up/down address counter with terminal-count flag, parameterised by ADDR_W and DEPTH.

Test Plan:
- Clean 1024x8 RAM, start pulse -> busy for 10241 cycles; done=1 after edge 10241; fail=0; exactly 5120 writes and 5120 reads counted on mem_wr.
- RAM model with bit 3 of address 5 stuck-at-1, BG=00 -> fail=1, fail_elem=1, fail_addr=5, fail_exp=00, fail_act=08; done one edge after the compare cycle; no further mem_wr pulses.
- RAM model forcing address LSB to 1 -> fail_elem=1, fail_addr=1, fail_exp=00, fail_act=FF.
- DEPTH=16, BG=8'h55, STOP_ON_FAIL=0, stuck-at-0 on bit 0 of address 15:
  - done after edge 161;
  - first syndrome: elem 1, addr 15, exp 55, act 54;
  - later miscompares leave fail_* unchanged.
- rst_n pulled low during M3 (address 700) -> mem_wr=0 and busy/done/fail=0 within the same cycle; after release, no RAM writes until start; a new start runs the full 10241-cycle pass.
- start re-pulsed while busy at cycle 3000 -> ignored (completion still at edge 10241); start pulsed in DONE -> done/fail clear at that edge and a new run begins.
